// File: rtl/angle_lcd_formatter.sv
// Scales a 12-bit angle sample to whole degrees and converts it to BCD.
// Streams a 5-byte address/digits/degree-symbol frame to an LCD controller, one busy-gated write per byte.
module angle_lcd_formatter #(
  parameter logic [7:0] DDRAM_ADDR  = 8'h00,
  parameter logic [7:0] DEG_CHAR    = 8'hDF,
  parameter int         ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] angle_in,
  input  logic        sample_valid,
  input  logic        disp_busy,
  output logic [7:0]  char_data,
  output logic        char_rs,
  output logic        char_write,
  output logic        frame_busy,
  output logic        sample_dropped
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, SCALE, BCD, EMIT, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state, state_nx;
  logic [11:0]   sample;
  logic [11:0]   pend_data;
  logic          pend_valid;
  logic [20:0]   dd;        // {hundreds, tens, units, binary} double-dabble register
  logic [3:0]    it_cnt;
  logic [2:0]    idx;
  logic [TW-1:0] to_cnt;
  logic [20:0]   ext, prod;
  logic          to_last, byte_done, last_byte;
  logic [7:0]    cur_byte;
  logic          cur_rs;
  logic [3:0]    hun, ten, uni;

  // deg = (a * 360) >> 12, with 360 = 256 + 64 + 32 + 8
  assign ext  = {9'd0, sample};
  assign prod = (ext << 8) + (ext << 6) + (ext << 5) + (ext << 3);

  assign hun = dd[20:17];
  assign ten = dd[16:13];
  assign uni = dd[12:9];

  assign to_last   = (to_cnt == TW'(ACK_TIMEOUT - 1));
  assign last_byte = (idx == 3'd4);
  assign byte_done = (state == WAIT_DONE && !disp_busy) ||
                     (state == WAIT_ACK && !disp_busy && to_last);
  assign frame_busy = (state != IDLE) || pend_valid;

  function automatic logic [20:0] dab_step(input logic [20:0] v);
    logic [20:0] r;
    r = v;
    for (int i = 0; i < 3; i++)
      if (r[9+4*i +: 4] >= 4'd5) r[9+4*i +: 4] = r[9+4*i +: 4] + 4'd3;
    return r << 1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (pend_valid || sample_valid) state_nx = SCALE;
      SCALE:     state_nx = BCD;
      BCD:       if (it_cnt == 4'd8) state_nx = EMIT;
      EMIT:      if (!disp_busy) state_nx = WAIT_ACK;
      WAIT_ACK:  if (disp_busy) state_nx = WAIT_DONE;
                 else if (to_last) state_nx = last_byte ? IDLE : EMIT;
      WAIT_DONE: if (!disp_busy) state_nx = last_byte ? IDLE : EMIT;
      default:   state_nx = IDLE;
    endcase
  end

  // Byte selected for the current frame position; leading zeros blank to space.
  always_comb begin
    cur_byte = 8'h80 | DDRAM_ADDR;
    cur_rs   = 1'b1;
    case (idx)
      3'd0:    cur_rs = 1'b0;
      3'd1:    cur_byte = (hun == 4'd0) ? 8'h20 : 8'h30 + {4'd0, hun};
      3'd2:    cur_byte = (hun == 4'd0 && ten == 4'd0) ? 8'h20 : 8'h30 + {4'd0, ten};
      3'd3:    cur_byte = 8'h30 + {4'd0, uni};
      default: cur_byte = DEG_CHAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample         <= '0;
      pend_data      <= '0;
      pend_valid     <= 1'b0;
      dd             <= '0;
      it_cnt         <= '0;
      idx            <= '0;
      to_cnt         <= '0;
      char_data      <= 8'h00;
      char_rs        <= 1'b0;
      char_write     <= 1'b0;
      sample_dropped <= 1'b0;
    end else begin
      char_write     <= 1'b0;
      sample_dropped <= 1'b0;

      // Pending slot: consumed in IDLE, refilled by any sample seen outside IDLE.
      if (state == IDLE) begin
        if (pend_valid) begin
          sample     <= pend_data;
          pend_valid <= sample_valid;
          if (sample_valid) pend_data <= angle_in;
        end else if (sample_valid) begin
          sample <= angle_in;
        end
      end else if (sample_valid) begin
        pend_data      <= angle_in;
        pend_valid     <= 1'b1;
        sample_dropped <= pend_valid;
      end

      case (state)
        SCALE: begin
          dd     <= prod >> 12;
          it_cnt <= '0;
          idx    <= '0;
        end
        BCD: begin
          dd     <= dab_step(dd);
          it_cnt <= it_cnt + 4'd1;
        end
        EMIT: if (!disp_busy) begin
          char_write <= 1'b1;
          char_data  <= cur_byte;
          char_rs    <= cur_rs;
          to_cnt     <= '0;
        end
        WAIT_ACK: if (!disp_busy && !to_last) to_cnt <= to_cnt + TW'(1);
        default: ;
      endcase

      if (byte_done && !last_byte) idx <= idx + 3'd1;
    end
  end

endmodule

// File: doc/angle_lcd_formatter.md
Name: angle_lcd_formatter

Overview:
- Sits directly upstream of the LCD display controller and drives it.
- Takes a raw 12-bit angle sample and scales it to whole degrees (0..359).
- Converts the degrees to decimal with a sequential shift-add-3 (double-dabble) and blanks leading zeros.
- Streams a 5-byte frame to the controller, one byte per busy-gated write strobe: set-DDRAM-address command, three digit characters, degree symbol.

Parameters:
- DDRAM_ADDR, 8'h00, cursor position of the frame; command byte sent is 8'h80 | DDRAM_ADDR.
- DEG_CHAR, 8'hDF, character code of the degree symbol.
- ACK_TIMEOUT, 64, max cycles to wait for disp_busy to rise after a write before treating the byte as accepted.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- angle_in  input  12  raw angle sample; 0..4095 maps to 0..<360 degrees
- sample_valid  input  1  one-cycle strobe qualifying angle_in
- disp_busy  input  1  high while the display controller is initialising or processing a byte
- char_data  output  8  byte presented to the display controller
- char_rs  output  1  0 = command byte, 1 = character data
- char_write  output  1  one-cycle write strobe; char_data and char_rs are valid in the same cycle
- frame_busy  output  1  high from sample latch until the last byte of the frame is accepted
- sample_dropped  output  1  one-cycle pulse when a pending sample is overwritten

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset values:
  - char_data=8'h00, char_rs=0, char_write=0, frame_busy=0, sample_dropped=0.
  - State IDLE; pending register empty.
- Scaling: deg = (angle_in * 360) >> 12, truncating.
  - Implemented as shift-add: (a<<8)+(a<<6)+(a<<5)+(a<<3).
  - 21-bit intermediate; result is 9 bits, range 0..359.
- BCD conversion: 9 iterations of add-3-then-shift, one per clock, producing hundreds/tens/units nibbles.
- Character mapping:
  - digit d -> 8'h30+d.
  - Hundreds digit of 0 -> 8'h20.
  - Tens digit -> 8'h20 when both hundreds and tens are 0.
  - Units digit is always shown.
- Frame order:
  - {rs=0, 8'h80|DDRAM_ADDR}
  - {rs=1, hundreds}
  - {rs=1, tens}
  - {rs=1, units}
  - {rs=1, DEG_CHAR}
- States:
  - IDLE: sample_valid (or pending full) -> latch sample, clear pending, frame_busy=1 -> SCALE.
  - SCALE: 1 cycle -> BCD.
  - BCD: exactly 9 cycles -> EMIT with byte index 0.
  - EMIT: if disp_busy=0, pulse char_write for one cycle with the current byte -> WAIT_ACK. Otherwise hold in EMIT with char_write=0.
  - WAIT_ACK: disp_busy=1 -> WAIT_DONE. ACK_TIMEOUT cycles without disp_busy=1 -> treat as done, same exit as WAIT_DONE.
  - WAIT_DONE: disp_busy=0 -> index<4: index+1, go to EMIT; index=4: frame_busy=0, go to IDLE.
- Latency: with disp_busy low, sample latched at edge N gives the first char_write high in cycle N+11.
- Outputs between strobes: char_data and char_rs hold their last driven value.
- Sample arriving while frame_busy=1: stored in a one-deep pending register.
  - If pending is already full, the new sample replaces it and sample_dropped pulses.
  - The in-progress frame is never aborted.
- Returning to IDLE with pending full: the next frame starts in the following cycle; frame_busy stays high with no gap.
- sample_valid in the same cycle as the last byte completes: goes to pending, not dropped.
- disp_busy high at start (controller still initialising): EMIT waits indefinitely; no write is issued.
- Reset asserted mid-frame: all outputs return to reset values immediately; pending is cleared; no further bytes are sent.

Test Plan:
- Reset, then angle_in=12'h400 with sample_valid; model controller busy for 100 cycles per byte -> bytes 80(rs0), 20, 39, 30, DF; frame_busy falls after the 5th byte.
- angle_in=12'hFFF -> 80, 33, 35, 39, DF. angle_in=12'h000 -> 80, 20, 20, 30, DF. angle_in=12'h01C (deg 2) -> 80, 20, 20, 32, DF.
- disp_busy held high 500 cycles after the sample -> no char_write until it falls; first write exactly 1 cycle after disp_busy=0 is sampled in EMIT.
- Three samples 12'h400, 12'h800, 12'hC00 spaced 5 cycles apart -> frame for 90, one sample_dropped pulse, then frame for 270 (80, 32, 37, 30, DF), then IDLE.
- Model never raises disp_busy -> each byte advances after ACK_TIMEOUT=64 cycles; full frame completes.
- Assert reset during the 3rd byte's WAIT_DONE -> char_write=0 and frame_busy=0 immediately; after release, no bytes are sent until a new sample arrives.
